// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage decoder and the divider.
// master = decoder side, slave = divider side.
interface div_unit_if #(parameter int XLEN = 32);
    logic            div_start;
    logic [2:0]      div_op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_kill;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    modport master (
        output div_start, div_op, dividend, divisor, div_kill,
        input  div_busy, div_done, div_result
    );

    modport slave (
        input  div_start, div_op, dividend, divisor, div_kill,
        output div_busy, div_done, div_result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; DIV_EARLY_OUT_EN short-cuts /0 and overflow.
// Latency 34 cycles from the accepting edge (1 for early-out cases); busy holds off new starts, which are dropped.
// No queueing: div_kill aborts in any state and suppresses div_done.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q;
    logic            sel_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            a_neg_d;
    logic            b_neg_d;
    logic            b_zero_d;
    logic [XLEN-1:0] a_abs_d;
    logic [XLEN-1:0] b_abs_d;
    logic [XLEN:0]   shift_d;
    logic            ge_d;
    logic [XLEN-1:0] rem_step_d;
    logic [XLEN-1:0] quo_fix_d;
    logic [XLEN-1:0] rem_fix_d;
`ifdef DIV_EARLY_OUT_EN
    logic            special_d;
    logic [XLEN-1:0] special_res_d;
`endif

    always_comb begin
        a_neg_d  = ~bus.div_op[0] & bus.dividend[XLEN-1];
        b_neg_d  = ~bus.div_op[0] & bus.divisor[XLEN-1];
        b_zero_d = (bus.divisor == '0);
        a_abs_d  = a_neg_d ? ('0 - bus.dividend) : bus.dividend;
        b_abs_d  = b_neg_d ? ('0 - bus.divisor)  : bus.divisor;

        // Partial remainder is 33 bits after the shift; the result always fits back in 32.
        shift_d    = {rem_q, quo_q[XLEN-1]};
        ge_d       = (shift_d >= {1'b0, dvs_q});
        rem_step_d = ge_d ? (shift_d[XLEN-1:0] - dvs_q) : shift_d[XLEN-1:0];

        quo_fix_d = q_neg_q ? ('0 - quo_q) : quo_q;
        rem_fix_d = r_neg_q ? ('0 - rem_q) : rem_q;

`ifdef DIV_EARLY_OUT_EN
        special_d = b_zero_d |
                    (~bus.div_op[0] && bus.dividend == {1'b1, {(XLEN-1){1'b0}}} && bus.divisor == '1);
        if (bus.div_op[1])
            special_res_d = b_zero_d ? bus.dividend : '0;
        else
            special_res_d = b_zero_d ? '1 : {1'b1, {(XLEN-1){1'b0}}};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_rem_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.div_kill) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.div_start && bus.div_op[2]) begin
                            sel_rem_q <= bus.div_op[1];
                            // Quotient sign fix is dropped for /0 so the all-ones result survives.
                            q_neg_q   <= (a_neg_d ^ b_neg_d) & ~b_zero_d;
                            r_neg_q   <= a_neg_d;
                            quo_q     <= a_abs_d;
                            dvs_q     <= b_abs_d;
                            rem_q     <= '0;
                            cnt_q     <= '0;
`ifdef DIV_EARLY_OUT_EN
                            if (special_d) begin
                                result_q <= special_res_d;
                                done_q   <= 1'b1;
                            end else begin
                                state_q <= CALC;
                            end
`else
                            state_q   <= CALC;
`endif
                        end
                    end
                    CALC: begin
                        rem_q <= rem_step_d;
                        quo_q <= {quo_q[XLEN-2:0], ge_d};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN-1))
                            state_q <= FIX;
                    end
                    FIX: begin
                        result_q <= sel_rem_q ? rem_fix_d : quo_fix_d;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.div_busy   = (state_q != IDLE);
    assign bus.div_done   = done_q;
    assign bus.div_result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, kill, reset and start-acceptance rules.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a start for one edge; returns just after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.div_op    = op;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.div_start = 1'b1;
        @(posedge clk);
        #1;
        bus.div_start = 1'b0;
    endtask

    // lat counts edges since the start cycle, including the accepting edge.
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!bus.div_done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b);
        wait_done(1, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.div_result, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        bus.div_start = 1'b0;
        bus.div_op    = 3'b000;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.div_kill  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, bus.div_busy}, 32'd0);
        check("reset done", {31'b0, bus.div_done}, 32'd0);
        check("reset result", bus.div_result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic signed/unsigned vectors
        run("div 100/7", OP_DIV, 32'd100, 32'd7, 32'd14, 34);
        run("rem 100/7", OP_REM, 32'd100, 32'd7, 32'd2, 34);
        run("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run("rem -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run("divu big/2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34);
        run("div 100/-7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34);

        // Divide by zero and signed overflow
        run("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, ZLAT);
        run("remu 5/0", OP_REMU, 32'd5, 32'd0, 32'd5, ZLAT);
        run("div -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, ZLAT);
        run("rem -5/0", OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, ZLAT);
        run("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ZLAT);
        run("rem ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, ZLAT);
        run("divu 0x80000000/-1", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
        run("divu big/2 again", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34);

        // Kill at cycle 10 of CALC
        issue(OP_DIVU, 32'd1000, 32'd3);
        check("busy after accept", {31'b0, bus.div_busy}, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        bus.div_kill = 1'b1;
        @(posedge clk);
        #1;
        bus.div_kill = 1'b0;
        check("kill busy", {31'b0, bus.div_busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.div_done) pulses++;
        end
        check("kill no done", 32'(pulses), 32'd0);
        check("kill result held", bus.div_result, 32'h7FFFFFFC);
        run("divu 9/3 after kill", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Kill and start together: kill wins
        bus.div_kill = 1'b1;
        issue(OP_DIVU, 32'd50, 32'd5);
        bus.div_kill = 1'b0;
        check("kill+start busy", {31'b0, bus.div_busy}, 32'd0);

        // Invalid op is ignored
        issue(3'b001, 32'd50, 32'd5);
        check("invalid op busy", {31'b0, bus.div_busy}, 32'd0);
        check("invalid op done", {31'b0, bus.div_done}, 32'd0);

        // Back-to-back: second start in the done cycle of the first
        run("b2b first", OP_DIV, 32'd100, 32'd7, 32'd14, 34);
        check("busy low in done cycle", {31'b0, bus.div_busy}, 32'd0);
        run("b2b second", OP_REMU, 32'd23, 32'd5, 32'd3, 34);

        // Start while busy is dropped
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(6, lat);
        check("busy start latency", 32'(lat), 32'd34);
        check("busy start result", bus.div_result, 32'd14);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.div_done) pulses++;
        end
        check("busy start not queued", 32'(pulses), 32'd0);

        // Async reset mid-CALC
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst busy", {31'b0, bus.div_busy}, 32'd0);
        check("rst done", {31'b0, bus.div_done}, 32'd0);
        check("rst result", bus.div_result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run("after rst", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting directly downstream of the instruction decoder in the execute stage. It consumes the decoder's `div_start` / `div_op` pulse together with the register-file operands. It produces a single 32-bit result with a one-cycle `div_done` strobe, and holds `div_busy` so the pipeline can stall around the multi-cycle operation.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `div_start`  in  1  request from decoder; sampled only when `div_busy`=0
- `div_op`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit2=0 means invalid
- `dividend`  in  32  rs1 value; sampled with an accepted start
- `divisor`  in  32  rs2 value; sampled with an accepted start
- `div_kill`  in  1  pipeline flush; aborts any operation in flight
- `div_busy`  out  1  high while an operation is in progress
- `div_done`  out  1  one-cycle pulse; `div_result` is valid during it
- `div_result`  out  32  quotient or remainder; held until the next `div_done`

## Operation
States: IDLE, CALC, FIX.
- **IDLE:** `div_start`=1, `div_op[2]`=1 and `div_kill`=0 means the start is accepted:
  - latch `op`;
  - signed ops (`div_op[0]`=0): latch |dividend| and |divisor|, plus `q_neg` = sign(a) XOR sign(b) and `r_neg` = sign(a);
  - unsigned ops: signs are ignored.
  - Clear the remainder register, set iteration counter = 0, then go to CALC.
  - A start with `div_op[2]`=0 is ignored.
- **CALC:** one restoring step per cycle:
  - form {rem,quo} shifted left by 1;
  - if rem >= divisor, set rem -= divisor and quo[0]=1;
  - the subtraction is 33 bits wide;
  - after 32 steps (counter 31 → wrap) go to FIX.
- **FIX:**
  - apply sign correction: negate quo if `q_neg`, negate rem if `r_neg`;
  - select the quotient (`div_op[1]`=0) or the remainder (`div_op[1]`=1) into `div_result`;
  - assert `div_done` and go to IDLE.
- **Divide by zero** (the raw algorithm yields these naturally; the sign fix is suppressed):
  - quotient = 0xFFFFFFFF;
  - remainder = dividend.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0. The unsigned-magnitude path produces this; it must be checked.
- `div_kill` in any state: go to IDLE next edge, no `div_done`, `div_result` unchanged. If `div_kill` and `div_start` are high together, kill wins.
- `div_busy` = (state != IDLE).

## Timing
- Reset: state = IDLE; `div_busy`=0, `div_done`=0, `div_result`=0; all internal registers cleared.
- Start accepted at edge E0. CALC occupies edges E1..E32. FIX at E33 registers the result.
- `div_done` is high during the cycle following E33: latency is 34 cycles from the accepting edge.
- `div_busy` rises the cycle after E0 and is low in the `div_done` cycle. A new start in that cycle is accepted, so back-to-back issue is possible.
- `div_start` while `div_busy`=1: ignored, with no queueing.
- `rst` mid-operation: immediate return to IDLE, with outputs at their reset values.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - at acceptance, divisor==0 or signed overflow is detected and the architected result is written directly;
  - state goes to FIX-equivalent completion, so `div_done` is high the cycle after E0 (latency 1) and `div_busy` never asserts.
- Undefined: these cases run the full 34-cycle path and produce identical results.

## Test plan
- DIV 100 / 7 → `div_done` at 34 cycles, `div_result`=14; REM same operands → 2.
- DIV -7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV -5/0 → 0xFFFFFFFF, REM -5/0 → 0xFFFFFFFB. Latency is 1 with `DIV_EARLY_OUT_EN`, 34 without.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- `div_kill` at cycle 10 of CALC → no `div_done`, `div_busy` low next cycle, `div_result` still the previous value; then start DIVU 9/3 → 3.
- Back-to-back: second start issued in the `div_done` cycle of the first → accepted, done 34 cycles later. A start pulsed while busy → ignored; `rst` asserted mid-CALC → all outputs 0.
